mux_func_sweeper: RTL

- Sequential stimulus/check stage that sits in front of the 3-input mux-implemented logic function block (`sel_exp`).
- Drives its `A`/`B`/`C` inputs through all 8 combinations and waits a programmable settle time before sampling `L`.
- Assembles the 8-bit truth table and compares it against an expected table latched at start.
- Used as the self-test / characterisation front end for combinational function blocks built on `data_sel`.

---
 rtl/mux_sweep_pkg.sv | 19 +
 rtl/first_diff_enc.sv | 28 ++
 rtl/mux_func_sweeper.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mux_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_sweep_pkg
// Description : Shared constants for the mux function sweeper: FSM state
//               encoding, truth-table width and settle-time ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_sweep_pkg;

    localparam int TT_W       = 8;
    localparam int SETTLE_MAX = 15;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage : mux_sweep_pkg
`default_nettype wire

// File: rtl/first_diff_enc.sv
`default_nettype none
// ============================================================================
// Module      : first_diff_enc
// Description : 8-to-3 priority encoder returning the index of the lowest set
//               bit of a difference vector; returns 0 when no bit is set.
// Ports       : diff_i [TT_W-1:0] - mismatch vector (tt ^ expected)
//               idx_o  [2:0]      - lowest set bit position
// Revision    : 1.0 - initial release
// ============================================================================
module first_diff_enc
    import mux_sweep_pkg::*;
(
    input  logic [TT_W-1:0] diff_i,
    output logic [2:0]      idx_o
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        idx_o = 3'd0;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (diff_i[i]) begin
                idx_o = 3'(i);
            end
        end
    end

endmodule : first_diff_enc
`default_nettype wire

// File: rtl/mux_func_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : mux_func_sweeper
// Description : Sweeps {A,B,C} through all 8 combinations, holds each for
//               SETTLE cycles, samples L into a truth table and compares it
//               with the expected table latched at start.
// Ports       : clk, rst (sync, active high)
//               start, abort          - sweep control
//               exp_tt[7:0]           - expected table, latched on accept
//               L                     - function output under test
//               A, B, C               - registered stimulus (idx[2:0])
//               busy, done            - status; done is a 1-cycle pulse
//               tt[7:0], match,
//               err_idx[2:0]          - result of the last sweep
// Revision    : 1.0 - initial release
// ============================================================================
module mux_func_sweeper
    import mux_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TT_W-1:0] exp_tt,
    input  logic            L,
    output logic            A,
    output logic            B,
    output logic            C,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic            match,
    output logic [2:0]      err_idx
);

    generate
        if (SETTLE < 1 || SETTLE > SETTLE_MAX) begin : g_bad_settle
            $error("mux_func_sweeper: SETTLE out of range 1..15");
        end
    endgenerate

    localparam logic [3:0] c_last = 4'(SETTLE - 1);

    logic [1:0]      state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      wait_q, wait_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic            match_q, match_d;
    logic [2:0]      err_q, err_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [2:0]      abc_q, abc_d;

    logic            w_sample;
    logic [2:0]      w_first;

    assign w_sample = (wait_q == c_last);

    first_diff_enc u_enc (
        .diff_i (tt_q ^ exp_q),
        .idx_o  (w_first)
    );

    // State register; the datapath registers ride along with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            wait_q  <= 4'd0;
            exp_q   <= '0;
            tt_q    <= '0;
            match_q <= 1'b0;
            err_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abc_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            match_q <= match_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abc_q   <= abc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = APPLY;
            APPLY: begin
                if (abort)                          state_d = IDLE;
                else if (w_sample && idx_q == 3'd7) state_d = CHECK;
            end
            CHECK:   state_d = abort ? IDLE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d   = idx_q;
        wait_d  = wait_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        match_d = match_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        abc_d   = abc_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = 3'd0;
                    wait_d  = 4'd0;
                    exp_d   = exp_tt;
                    tt_d    = '0;
                    match_d = 1'b0;
                    err_d   = 3'd0;
                    busy_d  = 1'b1;
                    abc_d   = 3'd0;
                end
            end
            APPLY: begin
                // Abort wins over a sample falling on the same edge.
                if (abort) begin
                    busy_d = 1'b0;
                    abc_d  = 3'd0;
                end else if (w_sample) begin
                    tt_d[idx_q] = L;
                    if (idx_q == 3'd7) begin
                        abc_d = 3'd0;
                    end else begin
                        // Stimulus advances on the same edge as the sample.
                        idx_d  = idx_q + 3'd1;
                        wait_d = 4'd0;
                        abc_d  = idx_q + 3'd1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            CHECK: begin
                busy_d = 1'b0;
                if (!abort) begin
                    match_d = (tt_q == exp_q);
                    err_d   = w_first;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign A       = abc_q[2];
    assign B       = abc_q[1];
    assign C       = abc_q[0];
    assign busy    = busy_q;
    assign done    = done_q;
    assign tt      = tt_q;
    assign match   = match_q;
    assign err_idx = err_q;

endmodule : mux_func_sweeper
`default_nettype wire
